// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 key event queue.
// Frame layout, event layout and the modifier scancodes.
package kbd_pkg;

  localparam int START    = 0;
  localparam int DATA_LSB = 1;
  localparam int PARITY   = 9;
  localparam int STOP     = 10;
  localparam int FRAME_W  = 11;
  localparam int EVT_W    = 10;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] sc;
  } key_evt_t;

  // Start low, stop high, odd parity over data+parity bits.
  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    return !f[START] && f[STOP] && (^f[PARITY:DATA_LSB]);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous show-ahead FIFO for key events.
// Read data is forced to zero while empty; ovf pulses on a dropped write.
module key_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = EVT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign ovf     = wr_en & full & ~do_rd;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 frame CDC, validation, modifier tracking and event queue.
// Optional auto-repeat suppression with TYPEMATIC_FILTER_EN.
module ps2_key_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_latch,
  input  logic               release_key,
  input  logic               extended_code,
  input  logic               reset_required,
  input  logic               rd_en,
  output logic [EVT_W-1:0]   event_data,
  output logic               event_valid,
  output logic               shift_held,
  output logic               ctrl_held,
  output logic               alt_held,
  output logic               frame_error,
  output logic               overflow,
  input  logic               err_clr
);

  localparam int S = SYNC_STAGES;

  logic [S-1:0]       lat_sync_q, rr_sync_q, fill_q;
  logic               lat_s, rr_s, lat_prev_q, armed_q, capture;
  logic               cap_vld_q, cap_rel_q, cap_ext_q;
  logic [FRAME_W-1:0] cap_frame_q;
  logic               shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic               ferr_q, ferr_d, ovf_q, ovf_d;
  logic               accept, bad, rpt, wr_en, fifo_ovf;
  logic               fifo_empty, fifo_full, set_v;
  logic [7:0]         sc;
  key_evt_t           evt;

  assign lat_s   = lat_sync_q[S-1];
  assign rr_s    = rr_sync_q[S-1];
  assign capture = lat_s & ~lat_prev_q & armed_q;

  // Synchronisers; fill_q marks when the chain holds post-reset samples,
  // so a latch already high across reset is not mistaken for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_sync_q <= '0;
      rr_sync_q  <= '0;
      fill_q     <= '0;
      lat_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      lat_sync_q <= {lat_sync_q[S-2:0], frame_latch};
      rr_sync_q  <= {rr_sync_q[S-2:0], reset_required};
      fill_q     <= {fill_q[S-2:0], 1'b1};
      lat_prev_q <= lat_s;
      armed_q    <= armed_q | (fill_q[S-1] & ~lat_s);
    end
  end

  // Capture the frame and qualifiers on the synced rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld_q   <= 1'b0;
      cap_rel_q   <= 1'b0;
      cap_ext_q   <= 1'b0;
      cap_frame_q <= '0;
    end else begin
      cap_vld_q <= capture & ~rr_s;
      if (capture) begin
        cap_rel_q   <= release_key;
        cap_ext_q   <= extended_code;
        cap_frame_q <= frame;
      end
    end
  end

  assign sc     = cap_frame_q[PARITY-1:DATA_LSB];
  assign evt    = '{rel: cap_rel_q, ext: cap_ext_q, sc: sc};
  assign accept = cap_vld_q & frame_ok(cap_frame_q);
  assign bad    = cap_vld_q & ~frame_ok(cap_frame_q);
  assign wr_en  = accept & ~rpt;
  assign set_v  = ~cap_rel_q;

`ifdef TYPEMATIC_FILTER_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;

  assign rpt = ~cap_rel_q & last_vld_q & (last_q == {cap_ext_q, sc});

  // Remember the last make; any release re-arms it.
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (accept && cap_rel_q) begin
      last_vld_d = 1'b0;
    end else if (accept) begin
      last_d     = {cap_ext_q, sc};
      last_vld_d = 1'b1;
    end
  end

  // Auto-repeat filter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign rpt = 1'b0;
`endif

  // Modifier and sticky error next state.
  always_comb begin
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    alt_d   = alt_q;
    if (wr_en) begin
      unique case (1'b1)
        (!cap_ext_q && (sc == SC_LSHIFT || sc == SC_RSHIFT)):
          shift_d = set_v;
        (sc == SC_CTRL): ctrl_d = set_v;
        (sc == SC_ALT):  alt_d  = set_v;
        default: ;
      endcase
    end
    ferr_d = (ferr_q & ~err_clr) | bad;
    ovf_d  = (ovf_q & ~err_clr) | fifo_ovf;
  end

  // Modifier and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  key_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (evt),
    .rd_en   (rd_en),
    .rd_data (event_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .ovf     (fifo_ovf)
  );

  assign event_valid = ~fifo_empty;
  assign shift_held  = shift_q;
  assign ctrl_held   = ctrl_q;
  assign alt_held    = alt_q;
  assign frame_error = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed self-checking bench for ps2_key_event_queue.
// Covers latency, validation, modifiers, overflow, error window, reset.
module tb_ps2_key_event_queue;

  localparam int S = 2;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] frame = '0;
  logic        frame_latch = 1'b0;
  logic        release_key = 1'b0;
  logic        extended_code = 1'b0;
  logic        reset_required = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [9:0]  event_data;
  logic        event_valid, shift_held, ctrl_held, alt_held;
  logic        frame_error, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame          (frame),
    .frame_latch    (frame_latch),
    .release_key    (release_key),
    .extended_code  (extended_code),
    .reset_required (reset_required),
    .rd_en          (rd_en),
    .event_data     (event_data),
    .event_valid    (event_valid),
    .shift_held     (shift_held),
    .ctrl_held      (ctrl_held),
    .alt_held       (alt_held),
    .frame_error    (frame_error),
    .overflow       (overflow),
    .err_clr        (err_clr)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkf(input logic [7:0] sc);
    return {1'b1, ~^sc, sc, 1'b0};
  endfunction

  task automatic begin_frame(input logic [10:0] f, input logic rel,
                             input logic ext);
    frame = f;
    release_key = rel;
    extended_code = ext;
    frame_latch = 1'b1;
  endtask

  task automatic end_frame();
    step(2);
    frame_latch = 1'b0;
    step(S + 3);
  endtask

  task automatic send(input logic [10:0] f, input logic rel,
                      input logic ext);
    begin_frame(f, rel, ext);
    step(S + 1);
    end_frame();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int nmk;
    step(1);
    chk("rst_valid", event_valid, 0);
    chk("rst_data", event_data, 0);
    chk("rst_shift", shift_held, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step(5);

    // latency and pop
    begin_frame(11'h438, 0, 0);
    step(S + 1);
    chk("lat_early", event_valid, 0);
    step(1);
    chk("lat_valid", event_valid, 1);
    chk("a_data", event_data, 10'h01C);
    end_frame();
    chk("a_still", event_valid, 1);
    pop();
    chk("a_popped", event_valid, 0);

    // rd_en while empty
    pop();
    chk("empty_rd", event_valid, 0);

    // bad parity
    send(11'h638, 0, 0);
    chk("bad_valid", event_valid, 0);
    chk("bad_ferr", frame_error, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ferr_clr", frame_error, 0);

    // bad stop and start bits
    send(11'h038, 0, 0);
    chk("stop_ferr", frame_error, 1);
    chk("stop_valid", event_valid, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    send(11'h439, 0, 0);
    chk("start_ferr", frame_error, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;

    // modifiers
    send(11'h624, 0, 0);
    chk("shift_set", shift_held, 1);
    chk("shift_mk", event_data, 10'h012);
    pop();
    send(11'h624, 1, 0);
    chk("shift_clr", shift_held, 0);
    chk("shift_brk", event_data, 10'h212);
    pop();
    send(mkf(8'h14), 0, 1);
    chk("ctrl_set", ctrl_held, 1);
    chk("ctrl_mk", event_data, 10'h114);
    pop();
    send(mkf(8'h11), 0, 0);
    chk("alt_set", alt_held, 1);
    chk("alt_mk", event_data, 10'h011);
    chk("alt_shift", shift_held, 0);
    pop();
    send(mkf(8'h59), 0, 1);
    chk("eshift", shift_held, 0);
    pop();
    send(mkf(8'h59), 0, 0);
    chk("rshift", shift_held, 1);
    pop();
    send(mkf(8'h12), 1, 0);
    chk("lshift_brk", shift_held, 0);
    pop();

    // overflow
    for (int i = 1; i <= 9; i++) send(mkf(8'(i)), 0, 0);
    chk("ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop", event_data, 32'(i));
      pop();
    end
    chk("ovf_empty", event_valid, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // full with simultaneous read and write
    for (int i = 0; i < 8; i++) send(mkf(8'(8'h21 + i)), 0, 0);
    chk("full_ovf0", overflow, 0);
    begin_frame(mkf(8'h29), 0, 0);
    step(S + 1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    end_frame();
    chk("rw_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("rw_pop", event_data, 32'(8'h22 + i));
      pop();
    end
    chk("rw_empty", event_valid, 0);

    // err_clr coinciding with a new error
    begin_frame(11'h638, 0, 0);
    step(S + 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    end_frame();
    chk("set_wins", frame_error, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("setw_clr", frame_error, 0);

    // protocol error window
    reset_required = 1'b1;
    step(S + 1);
    send(11'h638, 0, 0);
    chk("rr_ferr", frame_error, 0);
    send(11'h438, 0, 0);
    chk("rr_valid", event_valid, 0);
    reset_required = 1'b0;
    step(S + 2);

    // async reset mid-sequence
    send(11'h624, 0, 0);
    send(11'h638, 0, 0);
    chk("pre_shift", shift_held, 1);
    chk("pre_ferr", frame_error, 1);
    begin_frame(11'h438, 0, 0);
    step(1);
    rst = 1'b1;
    #1;
    chk("ar_valid", event_valid, 0);
    chk("ar_data", event_data, 0);
    chk("ar_shift", shift_held, 0);
    chk("ar_ferr", frame_error, 0);
    step(1);
    rst = 1'b0;
    step(6);
    chk("ar_nocap", event_valid, 0);
    frame_latch = 1'b0;
    step(S + 3);
    send(11'h438, 0, 0);
    chk("ar_fresh", event_valid, 1);
    chk("ar_fdata", event_data, 10'h01C);
    pop();
    send(11'h438, 1, 0);
    chk("brk_data", event_data, 10'h21C);
    pop();

    // repeated makes
`ifdef TYPEMATIC_FILTER_EN
    nmk = 1;
`else
    nmk = 3;
`endif
    for (int i = 0; i < 3; i++) send(11'h438, 0, 0);
    for (int i = 0; i < nmk; i++) begin
      chk("rep_data", event_data, 10'h01C);
      pop();
    end
    chk("rep_empty", event_valid, 0);
    send(11'h438, 1, 0);
    send(11'h438, 0, 0);
    chk("rb_brk", event_data, 10'h21C);
    pop();
    chk("rb_mk", event_data, 10'h01C);
    pop();
    chk("rb_empty", event_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
